// File: rtl/switch_send_queue_pkg.sv
// Shared message types and head-FSM encodings for the switch send path.
// The message struct is sized for the default switch configuration and is reused by Switch and VecCore.
package switch_send_queue_pkg;

  localparam int LANE_BITS      = 32;
  localparam int DEF_CORE_SIZE  = 2;
  localparam int DEF_WIDTH      = 16;
  localparam int DEF_ADDR_SIZE  = $clog2(DEF_CORE_SIZE);

  typedef struct packed {
    logic [DEF_ADDR_SIZE-1:0]               core_idx;
    logic [DEF_WIDTH-1:0][LANE_BITS-1:0]    data;
  } msg_t;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

endpackage

// File: rtl/switch_send_queue_msg_fifo.sv
// Generic circular message store with wrapping pointers and an occupancy count.
// Push when full and pop when empty are ignored, so callers may gate loosely.
module msg_fifo #(
  parameter int WIDTH      = 33,
  parameter int DEPTH      = 4,
  parameter int COUNT_SIZE = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic [COUNT_SIZE-1:0] count,
  output logic                  full
);

  localparam int                    PTR_SIZE  = $clog2(DEPTH);
  localparam logic [PTR_SIZE-1:0]   LAST_PTR  = PTR_SIZE'(DEPTH - 1);
  localparam logic [COUNT_SIZE-1:0] DEPTH_CNT = COUNT_SIZE'(DEPTH);

  logic [WIDTH-1:0]      mem_r [DEPTH];
  logic [PTR_SIZE-1:0]   wr_ptr_r;
  logic [PTR_SIZE-1:0]   rd_ptr_r;
  logic [COUNT_SIZE-1:0] count_r;
  logic [COUNT_SIZE-1:0] count_next_s;
  logic                  do_push_s;
  logic                  do_pop_s;

  function automatic logic [PTR_SIZE-1:0] ptr_inc(input logic [PTR_SIZE-1:0] ptr);
    if (ptr == LAST_PTR) begin
      return {PTR_SIZE{1'b0}};
    end else begin
      return ptr + PTR_SIZE'(1);
    end
  endfunction

  // Qualify requests against occupancy and compute the next count.
  always_comb begin
    do_push_s    = push && (count_r != DEPTH_CNT);
    do_pop_s     = pop && (count_r != {COUNT_SIZE{1'b0}});
    count_next_s = count_r;
    case ({do_push_s, do_pop_s})
      2'b10:   count_next_s = count_r + COUNT_SIZE'(1);
      2'b01:   count_next_s = count_r - COUNT_SIZE'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Pointers and count; storage is cleared too so the head reads zero after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_SIZE{1'b0}};
      rd_ptr_r <= {PTR_SIZE{1'b0}};
      count_r  <= {COUNT_SIZE{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      count_r <= count_next_s;
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == DEPTH_CNT);

endmodule

// File: rtl/switch_send_queue.sv
// Per-core outbound queue: the core enqueues {dest, vector} and the switch drains the oldest entry
// through a present/acknowledge handshake. Head fields come only from registered storage.
module switch_send_queue
  import switch_send_queue_pkg::*;
#(
  parameter int SWITCH_CORE_SIZE      = 2,
  parameter int SWITCH_WIDTH          = 16,
  parameter int DEPTH                 = 4,
  parameter int SWITCH_CORE_ADDR_SIZE = $clog2(SWITCH_CORE_SIZE),
  parameter int COUNT_SIZE            = $clog2(DEPTH + 1)
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       enq_valid,
  input  logic [SWITCH_CORE_ADDR_SIZE-1:0]           enq_core_idx,
  input  logic [SWITCH_WIDTH-1:0][LANE_BITS-1:0]     enq_data,
  output logic                                       enq_ready,
  output logic                                       send_ready,
  output logic [SWITCH_CORE_ADDR_SIZE-1:0]           send_core_idx,
  output logic [SWITCH_WIDTH-1:0][LANE_BITS-1:0]     send_data,
  input  logic                                       send_ok,
  output logic [COUNT_SIZE-1:0]                      count,
  output logic                                       empty
);

  localparam int                    DATA_BITS = SWITCH_WIDTH * LANE_BITS;
  localparam int                    MSG_BITS  = SWITCH_CORE_ADDR_SIZE + DATA_BITS;
  localparam logic [COUNT_SIZE-1:0] ONE_CNT   = COUNT_SIZE'(1);

  logic [0:0]            state_r;
  logic [0:0]            state_next_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  full_s;
  logic [COUNT_SIZE-1:0] count_s;
  logic [MSG_BITS-1:0]   wdata_s;
  logic [MSG_BITS-1:0]   head_s;

  msg_fifo #(
    .WIDTH      (MSG_BITS),
    .DEPTH      (DEPTH),
    .COUNT_SIZE (COUNT_SIZE)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (wdata_s),
    .rdata (head_s),
    .count (count_s),
    .full  (full_s)
  );

  // Handshake qualification: acknowledges are honoured only while a head is presented.
  always_comb begin
    push_s  = enq_valid && !full_s;
    pop_s   = send_ok && (state_r == ST_PRESENT);
    wdata_s = {enq_core_idx, enq_data};
  end

  // Head FSM: leave PRESENT only when the pop empties the queue with no refill this cycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (push_s) begin
          state_next_s = ST_PRESENT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_PRESENT: begin
        if (pop_s && !push_s && (count_s == ONE_CNT)) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_PRESENT;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  assign send_ready    = (state_r == ST_PRESENT);
  assign send_core_idx = head_s[MSG_BITS-1 -: SWITCH_CORE_ADDR_SIZE];
  assign send_data     = head_s[DATA_BITS-1:0];
  assign count         = count_s;
  assign empty         = (count_s == {COUNT_SIZE{1'b0}});
  assign enq_ready     = !full_s;

endmodule

// File: tb/tb_switch_send_queue.sv
// Directed self-checking bench for switch_send_queue at the default configuration.
module tb_switch_send_queue;

  logic              clock;
  logic              reset;
  logic              enq_valid;
  logic [0:0]        enq_core_idx;
  logic [15:0][31:0] enq_data;
  logic              enq_ready;
  logic              send_ready;
  logic [0:0]        send_core_idx;
  logic [15:0][31:0] send_data;
  logic              send_ok;
  logic [2:0]        count;
  logic              empty;

  int errors = 0;
  int checks = 0;

  switch_send_queue dut (
    .clock         (clock),
    .reset         (reset),
    .enq_valid     (enq_valid),
    .enq_core_idx  (enq_core_idx),
    .enq_data      (enq_data),
    .enq_ready     (enq_ready),
    .send_ready    (send_ready),
    .send_core_idx (send_core_idx),
    .send_data     (send_data),
    .send_ok       (send_ok),
    .count         (count),
    .empty         (empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // IEEE-754 single encoding of a small non-negative integer.
  function automatic logic [31:0] f32(input int n);
    int e;
    logic [31:0] m;
    if (n == 0) return 32'h0000_0000;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    m = 32'(n) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  // Lane i = (base + i) as a float.
  function automatic logic [15:0][31:0] payload(input int base);
    logic [15:0][31:0] p;
    for (int i = 0; i < 16; i++) p[i] = f32(base + i);
    return p;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic enq(input logic [0:0] idx, input logic [15:0][31:0] d);
    enq_valid = 1'b1; enq_core_idx = idx; enq_data = d;
    tick();
    enq_valid = 1'b0;
  endtask

  task automatic ack();
    send_ok = 1'b1;
    tick();
    send_ok = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; enq_valid = 1'b0; enq_core_idx = 1'b0; enq_data = '0; send_ok = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    checks++; if (send_ready !== 1'b0) begin errors++; $display("FAIL reset_send_ready got=%b exp=0", send_ready); end
    checks++; if (send_core_idx !== 1'b0) begin errors++; $display("FAIL reset_idx got=%b exp=0", send_core_idx); end
    checks++; if (send_data !== 512'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", send_data); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_enq_ready got=%b exp=1", enq_ready); end
  endtask

  task automatic test_single();
    logic [15:0][31:0] d;
    d = payload(0);
    enq_valid = 1'b1; enq_core_idx = 1'b1; enq_data = d;
    #1;
    checks++; if (send_ready !== 1'b0) begin errors++; $display("FAIL single_no_passthru got=%b exp=0", send_ready); end
    tick();
    enq_valid = 1'b0;
    checks++; if (send_ready !== 1'b1) begin errors++; $display("FAIL single_ready got=%b exp=1", send_ready); end
    checks++; if (send_core_idx !== 1'b1) begin errors++; $display("FAIL single_idx got=%b exp=1", send_core_idx); end
    checks++; if (send_data !== d) begin errors++; $display("FAIL single_data got=%h exp=%h", send_data, d); end
    checks++; if (d[15] !== 32'h4170_0000) begin errors++; $display("FAIL single_lane15_ref got=%h exp=41700000", d[15]); end
    ack();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty got=%b exp=1", empty); end
    checks++; if (send_ready !== 1'b0) begin errors++; $display("FAIL single_idle got=%b exp=0", send_ready); end
  endtask

  task automatic test_full();
    for (int k = 0; k < 4; k++) enq(1'(k), payload(16 * (k + 1)));
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", count); end
    checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL full_enq_ready got=%b exp=0", enq_ready); end
    enq(1'b1, payload(200));
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_drop_count got=%0d exp=4", count); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (send_core_idx !== 1'(k)) begin errors++; $display("FAIL full_order_idx%0d got=%b exp=%0d", k, send_core_idx, k % 2); end
      checks++; if (send_data !== payload(16 * (k + 1))) begin errors++; $display("FAIL full_order_data%0d got=%h", k, send_data); end
      ack();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_drain_empty got=%b exp=1", empty); end
  endtask

  task automatic test_simultaneous();
    enq(1'b0, payload(100));
    enq(1'b1, payload(120));
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL simul_pre_count got=%0d exp=2", count); end
    enq_valid = 1'b1; enq_core_idx = 1'b0; enq_data = payload(140); send_ok = 1'b1;
    tick();
    enq_valid = 1'b0; send_ok = 1'b0;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL simul_count got=%0d exp=2", count); end
    checks++; if (send_data !== payload(120) || send_core_idx !== 1'b1) begin errors++; $display("FAIL simul_head got=%b/%h exp second message", send_core_idx, send_data[0]); end
    ack();
    checks++; if (send_data !== payload(140) || send_ready !== 1'b1) begin errors++; $display("FAIL simul_third got=%b/%h", send_ready, send_data[0]); end
    ack();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL simul_empty got=%b exp=1", empty); end
  endtask

  task automatic test_wrap();
    logic [15:0][31:0] d;
    for (int k = 0; k < 7; k++) begin
      d = payload(30 + 3 * k);
      d[0] = 32'h7FC0_0001;
      d[1] = 32'h8000_0000;
      d[2] = 32'h0000_0001;
      d[3] = 32'hFF80_0000 + 32'(k);
      enq(1'(k), d);
      checks++; if (send_data !== d || send_core_idx !== 1'(k)) begin errors++; $display("FAIL wrap_pair%0d got=%b/%h exp=%0d/%h", k, send_core_idx, send_data[3:0], k % 2, d[3:0]); end
      ack();
    end
    checks++; if (empty !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL wrap_empty got=%b/%0d exp=1/0", empty, count); end
  endtask

  task automatic test_ok_when_empty();
    ack();
    checks++; if (count !== 3'd0 || send_ready !== 1'b0) begin errors++; $display("FAIL emptyok_state got=%0d/%b exp=0/0", count, send_ready); end
    enq(1'b1, payload(60));
    checks++; if (send_data !== payload(60) || count !== 3'd1) begin errors++; $display("FAIL emptyok_head got=%h/%0d exp=%h/1", send_data[0], count, f32(60)); end
    ack();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) enq(1'b1, payload(70 + k));
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL rstmid_pre got=%0d exp=3", count); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (send_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready got=%b exp=0", send_ready); end
    checks++; if (count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL rstmid_count got=%0d/%b exp=0/1", count, empty); end
    checks++; if (send_data !== 512'd0) begin errors++; $display("FAIL rstmid_data got=%h exp=0", send_data[0]); end
    tick();
    reset = 1'b1;
    tick();
    enq(1'b0, payload(90));
    checks++; if (send_ready !== 1'b1 || send_data !== payload(90) || count !== 3'd1) begin errors++; $display("FAIL rstmid_resume got=%b/%h/%0d", send_ready, send_data[0], count); end
    ack();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rstmid_drain got=%b exp=1", empty); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_simultaneous();
    test_wrap();
    test_ok_when_empty();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/switch_send_queue.md
# switch_send_queue

Per-core outbound message queue between a `VecCore` send port and one send port of the `Switch`. The core enqueues a destination core index and a `SWITCH_WIDTH`-lane vector in one cycle and continues executing. The queue presents the oldest entry to the switch and holds it until the switch acknowledges the transfer. This decouples core issue from the switch's rendezvous handshake, so a core can issue up to `DEPTH` sends before a receiver posts a matching request.

## Interface
Parameters:
- `SWITCH_CORE_SIZE`, default 2: number of cores on the switch.
- `SWITCH_WIDTH`, default 16: lanes per message (`shortreal` each).
- `DEPTH`, default 4: queue entries; must be ≥ 2.
- `SWITCH_CORE_ADDR_SIZE`, default `$clog2(SWITCH_CORE_SIZE)`: auto-generated, not overridden.
- `COUNT_SIZE`, default `$clog2(DEPTH+1)`: auto-generated.

Ports:
- `clock`, input, 1: single clock; all state on its rising edge.
- `reset`, input, 1: asynchronous, active-low; 0 clears all state immediately.
- `enq_valid`, input, 1: core presents a message this cycle.
- `enq_core_idx`, input, `SWITCH_CORE_ADDR_SIZE`: destination core.
- `enq_data`, input, `shortreal [SWITCH_WIDTH-1:0]`: payload.
- `enq_ready`, output, 1: queue can accept; transfer occurs when `enq_valid && enq_ready`.
- `send_ready`, output, 1: head entry valid; drives `Switch.send_ready`.
- `send_core_idx`, output, `SWITCH_CORE_ADDR_SIZE`: head destination.
- `send_data`, output, `shortreal [SWITCH_WIDTH-1:0]`: head payload.
- `send_ok`, input, 1: one-cycle pulse from the switch; head was delivered.
- `count`, output, `COUNT_SIZE`: occupied entries.
- `empty`, output, 1: `count == 0`; the core's `done`/barrier logic uses it to wait for drain.

## Operation
- Circular buffer of `DEPTH` entries {core_idx, data}; read and write pointers wrap at `DEPTH-1 -> 0`.
- Two-state FSM on head:
  - IDLE (empty): `send_ready` = 0. Goes to PRESENT in the cycle after an enqueue.
  - PRESENT: `send_ready` = 1 with head fields stable. On `send_ok`, pop and stay in PRESENT if `count` after the pop is > 0, else go to IDLE.
- `enq_ready = (count < DEPTH)`, combinational from registered `count`. There is no full-queue bypass: at `count == DEPTH`, a same-cycle `send_ok` does not make `enq_ready` high in that cycle.
- Simultaneous enqueue and `send_ok` with 0 < `count` < `DEPTH`: both occur and `count` is unchanged.
- `send_ok` while `send_ready` = 0 is ignored: no pop, no pointer change.
- Enqueue with `enq_ready` = 0 is dropped; the core must hold the message until accepted.
- Payload is passed bit-exact; no arithmetic, and NaN/denormals are preserved.
- Reset mid-operation discards all queued messages. The switch sees `send_ready` fall asynchronously.

## Timing
- Reset values: `send_ready` = 0, `send_core_idx` = 0, `send_data` = all 0.0, `count` = 0, `empty` = 1, `enq_ready` = 1, pointers = 0.
- Enqueue-to-`send_ready` latency is 1 cycle when empty; there is no same-cycle pass-through.
- After a `send_ok` pop, the next head appears on `send_core_idx`/`send_data` in the following cycle with `send_ready` still 1, so back-to-back sends proceed at one message per switch acknowledge.
- Head outputs are driven from registered storage, with no combinational path from `enq_*` to `send_*`.
- `count`, `empty` and `enq_ready` reflect state after the previous edge.

## Structure
- A shared `vec_pkg` holds the message struct type (`core_idx`, `data[SWITCH_WIDTH]`) reused by `Switch` and `VecCore`, plus the FSM state enum.
- One sub-module, `msg_fifo`, is natural: a generic storage array with pointers and count. `switch_send_queue` wraps it with the FSM and the switch-side handshake.
- In a multi-core top, one instance per core sits between `VecCore` send outputs and `Switch.send_*[i]`.

## Test plan
- Reset, then enqueue {idx 1, lanes 0.0..15.0} → `send_ready` = 1 exactly one cycle later with identical data; `send_ok` pulse → `empty` = 1 the next cycle.
- Enqueue 4 messages (idx 0,1,0,1) with no `send_ok` → `count` = 4, `enq_ready` = 0; a fifth `enq_valid` is not stored; four `send_ok` pulses deliver in FIFO order.
- At `count` = 2, assert `enq_valid` and `send_ok` in the same cycle → `count` stays 2 and the head advances to the second message.
- Write pointer wraps: 7 enqueue/dequeue pairs with `DEPTH` = 4 → all payloads match, including lane values NaN and -0.0 bit-exact.
- `send_ok` while empty → no state change and `count` stays 0.
- Drive `reset` low mid-queue with 3 entries → `send_ready` = 0 and `count` = 0 immediately, without waiting for a clock edge; normal operation resumes after release.
